// File: rtl/piso_frame_serializer.sv
// Parallel-in, serial-out frame serializer with valid/ready load, selectable bit
// order and an optional idle gap between frames.
module piso_frame_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  output logic         load_ready,
  output logic         serial_out,
  output logic         shift_en,
  output logic         frame_done,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   sreg;
  logic [CW-1:0]  bit_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           last_bit;
  logic           handshake;

  // Every output is decoded from registered state only; load_valid reaches no output.
  assign last_bit   = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
  assign load_ready = (state == ST_IDLE) || ((GAP == 0) && last_bit);
  assign handshake  = load_valid && load_ready;
  assign shift_en   = (state == ST_SHIFT);
  assign frame_done = last_bit;
  assign busy       = (state != ST_IDLE);
  assign serial_out = shift_en && (MSB_FIRST ? sreg[N-1] : sreg[0]);

  // NOTE: state_next gets its default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (handshake) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        // With no gap, a reload in the last bit keeps the burst contiguous.
        if (last_bit) begin
          if (GAP > 0)         state_next = ST_GAP;
          else if (!handshake) state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == LAST_GAP) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      // NOTE: the shift register is cleared too, so an aborted word never leaks into a later frame.
      state   <= ST_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_next;
      if (handshake) begin
        sreg    <= load_data;
        bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        sreg    <= MSB_FIRST ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

endmodule
